msp430_trace_buffer: RTL and testbench
======================================

// Module: msp430_trace_buffer
// PURPOSE
//  Parametrised multi-core instruction trace recorder, the cycle-accurate successor of the debug decode signals.
//  Per decode of the selected core it records {irq, pc, ir, cycles-since-previous-decode} into a circular buffer.
//  Supports an optional PC-match trigger with post-trigger depth, stop-on-full or wrap mode, and a valid/ready drain port.
//  Sits in the testbench/debug tier next to the core(s); no effect on core execution.
// PARAMETERS
//  NUM_CORES  2   cores observed; CSEL_W = max(1,$clog2(NUM_CORES))
//  DEPTH      16  trace entries, power of two, >=2; AW = $clog2(DEPTH)
//  CYC_W      8   width of per-entry cycle field (saturating)
//  POST_TRIG  4   entries captured after (not including) the trigger entry; 0..DEPTH-1
// PORTS
//  mclk         in   1              clock (core MCLK)
//  puc_rst      in   1              synchronous active-high reset
//  core_select  in   CSEL_W         core to trace; sampled on arm only
//  decode       in   NUM_CORES      per-core decode strobe
//  irq_detect   in   NUM_CORES      per-core IRQ accepted at decode
//  pc           in   16*NUM_CORES   per-core PC, core k at [16k+:16]
//  ir           in   16*NUM_CORES   per-core instruction register
//  arm          in   1              pulse: clear buffer, start capture
//  clear        in   1              pulse: abort, empty buffer, go IDLE
//  stop_full    in   1              1=freeze when full, 0=wrap (sampled on arm)
//  trig_en      in   1              enable PC-match trigger (sampled on arm)
//  trig_pc      in   16             trigger PC (sampled on arm)
//  rd_valid     out  1              oldest entry available
//  rd_ready     in   1              consumer accepts entry
//  rd_data      out  33+CYC_W       {irq, pc[15:0], ir[15:0], cycles[CYC_W-1:0]}
//  count        out  AW+1           entries held, 0..DEPTH
//  state        out  2              0 IDLE, 1 ARMED, 2 POST, 3 DONE
//  wrapped      out  1              at least one entry overwritten since arm
//  inst_number  out  32             decodes of traced core since arm (not saturating, wraps)
// BEHAVIOUR
//  Reset (puc_rst, sync): state=IDLE, count=0, wr/rd ptrs=0, wrapped=0, inst_number=0, rd_valid=0, rd_data=0.
//  Capture event = state in {ARMED,POST} and decode[sel]; entry written at wr_ptr on that mclk edge; 1-cycle latency to count.
//  cycles field: counter set to 1 on arm or capture event, else +1 saturating at 2^CYC_W-1; entry stores current value.
//   Back-to-back decodes -> 1; first entry after arm = cycles since arm.
//  FSM:
//   IDLE : arm -> ARMED (latch sel/stop_full/trig_en/trig_pc, ptrs=0, count=0, wrapped=0, inst_number=0).
//   ARMED: capture; if trig_en && pc[sel]==trig_pc -> POST (POST_TRIG=0 -> DONE); else if stop_full && count reaches DEPTH -> DONE.
//   POST : capture; after POST_TRIG further entries -> DONE. Wraps regardless of stop_full (keep newest).
//   DONE : capture frozen; drain allowed; arm -> ARMED (restart).
//  Full in wrap mode: write overwrites oldest, rd_ptr advances with wr_ptr, count stays DEPTH, wrapped=1.
//  Drain: rd_valid = (state==DONE) && count!=0; rd_data = mem[rd_ptr] combinational; pop on rd_valid&&rd_ready.
//   Oldest first; count decrements; no pop when count=0 (rd_valid=0, ready ignored).
//  clear in any state: ptrs=0, count=0, wrapped=0, state=IDLE. clear and arm same cycle: clear wins.
//  arm while ARMED/POST: restart capture (same as from IDLE). arm and decode same cycle: decode not captured.
//  core_select/trig changes while armed: ignored until next arm. decode of untraced cores: ignored.
//  Trigger entry itself is always captured; trigger checked only on capture events.
//  puc_rst mid-capture or mid-drain: full reset, all buffered data discarded (contents need not be cleared).
// TESTING
//  Wrap: DEPTH=16, stop_full=0, 20 decodes pc=0x100+2n -> DONE via clear? no: trig at n=19, POST_TRIG=0; drain 16 entries pc 0x108..0x126, wrapped=1.
//  Stop-full: stop_full=1, trig_en=0, 20 decodes -> DONE after 16th; count=16; drain pcs 0x100..0x11E, then rd_valid=0.
//  Post-trigger: trig_pc=0x110, POST_TRIG=4 -> DONE after decode at 0x118; last entry pc=0x118, trigger entry present.
//  Cycles: decodes at gaps 1,3,300 cycles, CYC_W=8 -> cycle fields 1,3,255; IRQ decode -> irq bit=1.
//  Core select: NUM_CORES=2, sel=1 at arm, core0 decodes only -> count stays 0; flip core_select later -> still core1 traced.
//  Control races: arm+clear same cycle -> IDLE; puc_rst while rd_valid=1 -> next cycle rd_valid=0, count=0, state=IDLE.

Source files
------------

// File: rtl/msp430_trace_buffer.sv
// Multi-core instruction trace recorder: captures {irq, pc, ir, cycles} per
// decode of the selected core into a circular buffer drained via valid/ready.
module msp430_trace_buffer #(
   parameter  int NUM_CORES = 2,
   parameter  int DEPTH     = 16,
   parameter  int CYC_W     = 8,
   parameter  int POST_TRIG = 4,
   localparam int CSEL_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
   localparam int AW        = $clog2(DEPTH),
   localparam int DW        = 33 + CYC_W
) (
   input  logic                    mclk,
   input  logic                    puc_rst,
   input  logic [CSEL_W-1:0]       core_select,
   input  logic [NUM_CORES-1:0]    decode,
   input  logic [NUM_CORES-1:0]    irq_detect,
   input  logic [16*NUM_CORES-1:0] pc,
   input  logic [16*NUM_CORES-1:0] ir,
   input  logic                    arm,
   input  logic                    clear,
   input  logic                    stop_full,
   input  logic                    trig_en,
   input  logic [15:0]             trig_pc,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [DW-1:0]           rd_data,
   output logic [AW:0]             count,
   output logic [1:0]              state,
   output logic                    wrapped,
   output logic [31:0]             inst_number
);

   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_POST  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              st;
   logic [CSEL_W-1:0]   sel_q;
   logic                stop_full_q;
   logic                trig_en_q;
   logic [15:0]         trig_pc_q;
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [AW:0]         cnt_q;
   logic                wrapped_q;
   logic [31:0]         inst_q;
   logic [CYC_W-1:0]    cyc_q;
   logic [AW:0]         post_q;
   logic [DW-1:0]       mem [DEPTH];

   logic                dec_s;
   logic                irq_s;
   logic [15:0]         pc_s;
   logic [15:0]         ir_s;
   logic                capturing;
   logic                cap;
   logic                full;
   logic                trig_hit;
   logic                post_last;
   logic                pop;

   // Select the traced core's signals using the selection latched at arm.
   always_comb begin
      dec_s = 1'b0;
      irq_s = 1'b0;
      pc_s  = '0;
      ir_s  = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         if (sel_q == CSEL_W'(k)) begin
            dec_s = decode[k];
            irq_s = irq_detect[k];
            pc_s  = pc[16*k +: 16];
            ir_s  = ir[16*k +: 16];
         end
      end
   end

   assign capturing = (st == S_ARMED) || (st == S_POST);
   assign cap       = capturing && dec_s && !arm && !clear;
   assign full      = (cnt_q == CW'(DEPTH));
   assign trig_hit  = trig_en_q && (pc_s == trig_pc_q);
   assign post_last = ((post_q + 1'b1) == CW'(POST_TRIG));
   assign rd_valid  = (st == S_DONE) && (cnt_q != '0);
   assign pop       = rd_valid && rd_ready;

   always_ff @(posedge mclk) begin
      if (cap) mem[wr_ptr] <= {irq_s, pc_s, ir_s, cyc_q};
   end

   always_ff @(posedge mclk) begin
      if (puc_rst) begin
         st          <= S_IDLE;
         sel_q       <= '0;
         stop_full_q <= 1'b0;
         trig_en_q   <= 1'b0;
         trig_pc_q   <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         cnt_q       <= '0;
         wrapped_q   <= 1'b0;
         inst_q      <= '0;
         cyc_q       <= CYC_W'(1);
         post_q      <= '0;
      end else begin
         if (arm || cap)
            cyc_q <= CYC_W'(1);
         else if (cyc_q != '1)
            cyc_q <= cyc_q + 1'b1;

         if (clear) begin
            st        <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt_q     <= '0;
            wrapped_q <= 1'b0;
         end else if (arm) begin
            st          <= S_ARMED;
            sel_q       <= core_select;
            stop_full_q <= stop_full;
            trig_en_q   <= trig_en;
            trig_pc_q   <= trig_pc;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt_q       <= '0;
            wrapped_q   <= 1'b0;
            inst_q      <= '0;
            post_q      <= '0;
         end else begin
            if (capturing && dec_s) inst_q <= inst_q + 32'd1;

            // When full, the oldest entry is overwritten and dropped.
            if (cap) begin
               wr_ptr <= wr_ptr + 1'b1;
               if (full) begin
                  rd_ptr    <= rd_ptr + 1'b1;
                  wrapped_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end else if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
               cnt_q  <= cnt_q - 1'b1;
            end

            unique case (st)
               S_ARMED: begin
                  if (cap) begin
                     if (trig_hit) begin
                        post_q <= '0;
                        st     <= (POST_TRIG == 0) ? S_DONE : S_POST;
                     end else if (stop_full_q &&
                                  cnt_q == CW'(DEPTH - 1)) begin
                        st <= S_DONE;
                     end
                  end
               end
               S_POST: begin
                  if (cap) begin
                     post_q <= post_q + 1'b1;
                     if (post_last) st <= S_DONE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign rd_data     = rd_valid ? mem[rd_ptr] : '0;
   assign count       = cnt_q;
   assign state       = st;
   assign wrapped     = wrapped_q;
   assign inst_number = inst_q;

endmodule

// File: tb/tb_msp430_trace_buffer.sv
// Directed bench for msp430_trace_buffer with a queue scoreboard of
// expected trace entries, compared oldest first while draining.
module tb_msp430_trace_buffer;

   localparam int DEPTH = 16;
   localparam int DW    = 41;

   logic          mclk = 1'b0;
   logic          puc_rst;
   logic [0:0]    core_select;
   logic [1:0]    decode;
   logic [1:0]    irq_detect;
   logic [31:0]   pc;
   logic [31:0]   ir;
   logic          arm;
   logic          clear;
   logic          stop_full;
   logic          trig_en;
   logic [15:0]   trig_pc;
   logic          rd_valid;
   logic          rd_ready;
   logic [DW-1:0] rd_data;
   logic [4:0]    count;
   logic [1:0]    state;
   logic          wrapped;
   logic [31:0]   inst_number;

   int checks = 0;
   int errors = 0;
   int edges_since = 0;
   logic [DW-1:0] exp_q[$];

   msp430_trace_buffer #(
      .NUM_CORES(2), .DEPTH(DEPTH), .CYC_W(8), .POST_TRIG(4)
   ) dut (
      .mclk(mclk), .puc_rst(puc_rst), .core_select(core_select),
      .decode(decode), .irq_detect(irq_detect), .pc(pc), .ir(ir),
      .arm(arm), .clear(clear), .stop_full(stop_full),
      .trig_en(trig_en), .trig_pc(trig_pc), .rd_valid(rd_valid),
      .rd_ready(rd_ready), .rd_data(rd_data), .count(count),
      .state(state), .wrapped(wrapped), .inst_number(inst_number)
   );

   always #5 mclk = ~mclk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge mclk);
      #1;
      edges_since++;
   endtask

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_arm(int s, logic sf, logic te, logic [15:0] tp);
      core_select = 1'(s);
      stop_full   = sf;
      trig_en     = te;
      trig_pc     = tp;
      arm = 1'b1;
      step();
      arm = 1'b0;
      edges_since = 0;
      exp_q.delete();
   endtask

   task automatic do_decode(int core, logic [15:0] p, logic [15:0] i,
                            logic q, int gap, bit cap);
      int cy;
      repeat (gap - 1) step();
      decode[core]         = 1'b1;
      irq_detect[core]     = q;
      pc[core*16 +: 16]    = p;
      ir[core*16 +: 16]    = i;
      step();
      decode     = '0;
      irq_detect = '0;
      if (cap) begin
         cy = (edges_since > 255) ? 255 : edges_since;
         exp_q.push_back({q, p, i, 8'(cy)});
         if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
         edges_since = 0;
      end
   endtask

   task automatic drain(string tag, int n);
      logic [DW-1:0] e;
      rd_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         chk({tag, "_valid"}, rd_valid, 1'b1);
         if (rd_valid !== 1'b1) break;
         e = exp_q.pop_front();
         chk(tag, rd_data, e);
         step();
      end
      rd_ready = 1'b0;
   endtask

   initial begin
      puc_rst = 1'b1; core_select = '0; decode = '0; irq_detect = '0;
      pc = '0; ir = '0; arm = 1'b0; clear = 1'b0; stop_full = 1'b0;
      trig_en = 1'b0; trig_pc = '0; rd_ready = 1'b0;
      repeat (3) step();
      puc_rst = 1'b0;
      chk("rst_state", state, 2'd0);
      chk("rst_count", count, 5'd0);
      chk("rst_valid", rd_valid, 1'b0);
      chk("rst_data", rd_data, '0);
      chk("rst_wrapped", wrapped, 1'b0);
      chk("rst_inst", inst_number, 32'd0);

      // wrap mode, trigger at n=15, four post entries
      do_arm(0, 1'b0, 1'b1, 16'h011E);
      chk("wrap_armed", state, 2'd1);
      for (int n = 0; n < 20; n++) begin
         do_decode(0, 16'(16'h100 + 2*n), 16'(16'h4000 + n), 1'b0, 1, 1);
         if (n == 15) chk("wrap_post", state, 2'd2);
      end
      chk("wrap_done", state, 2'd3);
      chk("wrap_count", count, 5'd16);
      chk("wrap_wrapped", wrapped, 1'b1);
      chk("wrap_inst", inst_number, 32'd20);
      chk("wrap_first", rd_data[40:8], {1'b0, 16'h0108, 16'h4004});
      drain("wrap_drain", 16);
      chk("wrap_empty_valid", rd_valid, 1'b0);
      chk("wrap_empty_count", count, 5'd0);

      // stop on full
      do_arm(0, 1'b1, 1'b0, 16'h0000);
      for (int n = 0; n < 20; n++) begin
         do_decode(0, 16'(16'h100 + 2*n), 16'(16'h5000 + n), 1'b0, 1, n < 16);
         if (n == 15) chk("sf_done", state, 2'd3);
      end
      chk("sf_count", count, 5'd16);
      chk("sf_wrapped", wrapped, 1'b0);
      drain("sf_drain", 16);
      chk("sf_empty_valid", rd_valid, 1'b0);
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      chk("sf_empty_count", count, 5'd0);

      // post-trigger depth
      do_arm(0, 1'b0, 1'b1, 16'h0110);
      for (int n = 0; n < 15; n++) begin
         do_decode(0, 16'(16'h100 + 2*n), 16'(16'h6000 + n), 1'b0, 1, n <= 12);
         if (n == 8) chk("pt_post", state, 2'd2);
      end
      chk("pt_done", state, 2'd3);
      chk("pt_count", count, 5'd13);
      drain("pt_drain", 13);

      // cycle field and irq bit
      do_arm(0, 1'b1, 1'b1, 16'h0204);
      do_decode(0, 16'h0200, 16'h7000, 1'b0, 1, 1);
      do_decode(0, 16'h0202, 16'h7001, 1'b1, 3, 1);
      do_decode(0, 16'h0204, 16'h7002, 1'b0, 300, 1);
      chk("cyc_sat", exp_q[2][7:0], 8'd255);
      for (int n = 0; n < 4; n++)
         do_decode(0, 16'(16'h206 + 2*n), 16'(16'h7003 + n), 1'b0, 1, 1);
      chk("cyc_done", state, 2'd3);
      chk("cyc_count", count, 5'd7);
      drain("cyc_drain", 7);

      // core select latched at arm
      do_arm(1, 1'b0, 1'b1, 16'h0300);
      for (int n = 0; n < 3; n++)
         do_decode(0, 16'h0300, 16'h8000, 1'b0, 2, 0);
      chk("cs_count0", count, 5'd0);
      chk("cs_state", state, 2'd1);
      chk("cs_inst0", inst_number, 32'd0);
      core_select = 1'b0;
      do_decode(0, 16'h0300, 16'h8001, 1'b0, 2, 0);
      chk("cs_flip_count", count, 5'd0);
      do_decode(1, 16'h0300, 16'h9000, 1'b0, 2, 1);
      chk("cs_trig", state, 2'd2);
      for (int n = 0; n < 4; n++)
         do_decode(1, 16'(16'h302 + 2*n), 16'(16'h9001 + n), 1'b0, 1, 1);
      chk("cs_count", count, 5'd5);
      chk("cs_inst", inst_number, 32'd5);
      drain("cs_drain", 5);

      // restart and clear
      do_arm(0, 1'b0, 1'b0, 16'h0000);
      for (int n = 0; n < 3; n++)
         do_decode(0, 16'(16'h500 + 2*n), 16'h0, 1'b0, 1, 1);
      chk("rs_count3", count, 5'd3);
      do_arm(0, 1'b0, 1'b0, 16'h0000);
      chk("rs_count0", count, 5'd0);
      chk("rs_inst0", inst_number, 32'd0);
      do_decode(0, 16'h0600, 16'h0, 1'b0, 1, 1);
      chk("rs_count1", count, 5'd1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr_state", state, 2'd0);
      chk("clr_count", count, 5'd0);
      do_decode(0, 16'h0602, 16'h0, 1'b0, 1, 0);
      chk("idle_count", count, 5'd0);

      // arm and clear together
      arm = 1'b1; clear = 1'b1;
      step();
      arm = 1'b0; clear = 1'b0;
      chk("armclr_state", state, 2'd0);

      // arm and decode together
      core_select = 1'b0; stop_full = 1'b0; trig_en = 1'b0;
      arm = 1'b1; decode[0] = 1'b1;
      step();
      arm = 1'b0; decode = '0;
      chk("armdec_state", state, 2'd1);
      chk("armdec_count", count, 5'd0);

      // reset while data is pending
      do_arm(0, 1'b0, 1'b1, 16'h0400);
      for (int n = 0; n < 5; n++)
         do_decode(0, 16'(16'h400 + 2*n), 16'h0, 1'b0, 1, 1);
      chk("prst_valid_before", rd_valid, 1'b1);
      puc_rst = 1'b1;
      step();
      puc_rst = 1'b0;
      chk("prst_valid", rd_valid, 1'b0);
      chk("prst_count", count, 5'd0);
      chk("prst_state", state, 2'd0);
      chk("prst_data", rd_data, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
